// File: rtl/tone_gen_pkg.sv
// Shared definitions for the square/triangle tone generator: default
// parameter values, the mode encoding and the polarity type.
package tone_gen_pkg;

  localparam int SAMPLE_W_DEFAULT = 16;
  localparam int PERIOD_W_DEFAULT = 20;

  typedef enum logic {
    MODE_SQUARE   = 1'b0,
    MODE_TRIANGLE = 1'b1
  } mode_e;

  typedef enum logic {
    POL_LOW  = 1'b0,
    POL_HIGH = 1'b1
  } polarity_e;

endpackage

// File: rtl/tone_phase_counter.sv
// Half-period counter and polarity tracker for the tone generator.
// Advances only on 'advance'. 'polarity' is the value the next sample uses.
// 'cycle_start' flags the first sample of a new period, i.e. the first high
// sample after a low stretch.
module tone_phase_counter
  import tone_gen_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                advance,
  input  logic [PERIOD_W-1:0] half_period,
  output polarity_e           polarity,
  output logic                cycle_start
);

  logic [PERIOD_W-1:0] cnt_q, cnt_nxt;
  polarity_e           pol_q, pol_nxt;
  polarity_e           prev_q, prev_nxt;
  logic [PERIOD_W:0]   cnt_inc;
  logic                wrap;

  // cnt+1 >= half_period is cnt >= half_period-1 without the underflow at
  // zero, so half_period of 0 or 1 wraps on every request.
  assign cnt_inc = {1'b0, cnt_q} + (PERIOD_W+1)'(1);
  assign wrap    = (cnt_inc >= {1'b0, half_period});

  // Next-state logic for counter, polarity and the previous-sample polarity.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    cnt_nxt  = cnt_q;
    pol_nxt  = pol_q;
    prev_nxt = prev_q;
    if (!en) begin
      cnt_nxt  = '0;
      pol_nxt  = POL_HIGH;
      prev_nxt = POL_HIGH;
    end else if (advance) begin
      prev_nxt = pol_q;
      if (wrap) begin
        cnt_nxt = '0;
        pol_nxt = (pol_q == POL_HIGH) ? POL_LOW : POL_HIGH;
      end else begin
        cnt_nxt = cnt_inc[PERIOD_W-1:0];
      end
    end
  end

  // State register with synchronous reset to the start of a high half-period.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      cnt_q  <= '0;
      pol_q  <= POL_HIGH;
      prev_q <= POL_HIGH;
    end else begin
      cnt_q  <= cnt_nxt;
      pol_q  <= pol_nxt;
      prev_q <= prev_nxt;
    end
  end

  assign polarity    = pol_q;
  assign cycle_start = en && (pol_q == POL_HIGH) && (prev_q == POL_LOW);

endmodule

// File: rtl/square_tone_gen.sv
// Stereo square-wave tone generator feeding an I2S serializer.
// One packed {left, right} sample is produced one cycle after each
// sample_req. Optional triangle mode is built only when TONE_TRIANGLE_EN is
// defined; otherwise mode and tri_step are ignored.
module square_tone_gen
  import tone_gen_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int PERIOD_W = PERIOD_W_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  sample_req,
  input  logic [PERIOD_W-1:0]   half_period,
  input  logic [SAMPLE_W-1:0]   amp_l,
  input  logic [SAMPLE_W-1:0]   amp_r,
  input  logic                  phase_inv,
  input  logic                  mode,
  input  logic [SAMPLE_W-1:0]   tri_step,
  output logic [2*SAMPLE_W-1:0] data,
  output logic                  data_valid,
  output logic                  cycle_done
);

  localparam logic [SAMPLE_W-1:0] MAG_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

  polarity_e           polarity;
  logic                cycle_start;
  logic [SAMPLE_W-1:0] mag_l, mag_r;
  logic [SAMPLE_W-1:0] sq_l, sq_r;
  logic [SAMPLE_W-1:0] sample_l, sample_r;
  logic                right_high;

  tone_phase_counter #(
    .PERIOD_W (PERIOD_W)
  ) u_phase (
    .clk         (CLK),
    .rst         (RST),
    .en          (en),
    .advance     (sample_req),
    .half_period (half_period),
    .polarity    (polarity),
    .cycle_start (cycle_start)
  );

  // Magnitudes are unsigned; clamp to the largest positive signed sample.
  assign mag_l = (amp_l > MAG_MAX) ? MAG_MAX : amp_l;
  assign mag_r = (amp_r > MAG_MAX) ? MAG_MAX : amp_r;

  assign right_high = (polarity == POL_HIGH) ^ phase_inv;
  assign sq_l       = (polarity == POL_HIGH) ? mag_l : -mag_l;
  assign sq_r       = right_high ? mag_r : -mag_r;

`ifdef TONE_TRIANGLE_EN
  logic signed [SAMPLE_W+1:0] level_q, level_step, bound, step, sum;
  logic                       dir_up_q, dir_up_step;
  logic [SAMPLE_W-1:0]        tri_l, tri_r;
  logic                       tri_active;

  assign bound      = signed'({2'b00, mag_l});
  assign step       = signed'({2'b00, tri_step});
  assign tri_active = en && (mode == MODE_TRIANGLE);

  // Triangle level after one step, saturating at +/-bound and turning there.
  always_comb begin
    level_step  = level_q;
    dir_up_step = dir_up_q;
    sum         = dir_up_q ? (level_q + step) : (level_q - step);
    if (dir_up_q) begin
      if (sum >= bound) begin
        level_step  = bound;
        dir_up_step = 1'b0;
      end else begin
        level_step = sum;
      end
    end else begin
      if (sum <= -bound) begin
        level_step  = -bound;
        dir_up_step = 1'b1;
      end else begin
        level_step = sum;
      end
    end
  end

  // Triangle state: restarts at 0 going up while disabled, steps per request.
  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      level_q  <= '0;
      dir_up_q <= 1'b1;
    end else if (sample_req && tri_active) begin
      level_q  <= level_step;
      dir_up_q <= dir_up_step;
    end
  end

  assign tri_l = level_step[SAMPLE_W-1:0];
  assign tri_r = phase_inv ? -tri_l : tri_l;
`else
  logic unused_tri_inputs;
  assign unused_tri_inputs = ^{mode, tri_step};
`endif

  // Select the sample for the next output word; silence while disabled.
  always_comb begin
    sample_l = sq_l;
    sample_r = sq_r;
`ifdef TONE_TRIANGLE_EN
    if (mode == MODE_TRIANGLE) begin
      sample_l = tri_l;
      sample_r = tri_r;
    end
`endif
    if (!en) begin
      sample_l = '0;
      sample_r = '0;
    end
  end

  // Output register: one word and one valid pulse per request, RST wins.
  always_ff @(posedge CLK) begin
    // NOTE: only the small output/state registers are reset; there is no storage array to clear.
    if (RST) begin
      data       <= '0;
      data_valid <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      data_valid <= sample_req;
      cycle_done <= sample_req & cycle_start;
      if (sample_req) begin
        data <= {sample_l, sample_r};
      end
    end
  end

endmodule
